// File: rtl/pkt_chk.sv
// -----------------------------------------------------------------------------
// pkt_chk -- receive-side packet checker for the pkt_if beat stream.
//
// Parses the header beat of every packet and checks each packet against it:
//   header [63:48] declared size in bytes
//          [47:32] flow number (only the low FLOW_CNT_WIDTH bits index a
//                  flow; the upper bits must be zero)
//          [31:0]  sequence number
// It also checks the per-flow sequence number. It keeps per-flow packet,
// byte, sequence-error and size-error counters, plus two global error
// counters (framing errors and out-of-range flows).
//
// Ports
//   clk_i, rst_i            clock, synchronous active-low reset
//   pkt_data_i/sop/eop/     input beat stream; byte 0 is [63:56], empty
//   empty/valid, ready_o    counts unused bytes on the eop beat only
//   stat_addr_i             flow selected for read / clear
//   stat_rd_en_i            read request; stat_valid_o pulses 1 cycle later
//   stat_clr_i              zero all counters of the selected flow
//   stat_*_o                snapshot of the selected flow, held until the
//                           next read
//   frame_err_cnt_o         beats arriving outside a packet, plus sops
//                           arriving inside a packet
//   bad_flow_cnt_o          packets whose flow number is >= FLOW_CNT
// -----------------------------------------------------------------------------
module pkt_chk #(
    parameter  int FLOW_CNT       = 16,
    localparam int FLOW_CNT_WIDTH = (FLOW_CNT == 1) ? 1 : $clog2(FLOW_CNT)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [63:0]               pkt_data_i,
    input  logic                      pkt_sop_i,
    input  logic                      pkt_eop_i,
    input  logic [2:0]                pkt_empty_i,
    input  logic                      pkt_valid_i,
    output logic                      pkt_ready_o,
    input  logic [FLOW_CNT_WIDTH-1:0] stat_addr_i,
    input  logic                      stat_rd_en_i,
    input  logic                      stat_clr_i,
    output logic [31:0]               stat_pkt_cnt_o,
    output logic [47:0]               stat_byte_cnt_o,
    output logic [15:0]               stat_seq_err_o,
    output logic [15:0]               stat_size_err_o,
    output logic                      stat_valid_o,
    output logic [15:0]               frame_err_cnt_o,
    output logic [15:0]               bad_flow_cnt_o
);

    localparam logic [1:0] ST_WAIT_SOP = 2'd0;
    localparam logic [1:0] ST_IN_PKT   = 2'd1;
    localparam logic [1:0] ST_DROP     = 2'd2;

    localparam logic [16:0] FLOW_LIMIT = 17'(FLOW_CNT);
    localparam logic [16:0] BYTES_SAT  = 17'h1FFFF;

    // ---------------------------------------------------------------- state
    logic [1:0]                state_q, state_d;
    logic                      ready_q, ready_d;
    logic [15:0]               hdr_size_q, hdr_size_d;
    logic [FLOW_CNT_WIDTH-1:0] hdr_flow_q, hdr_flow_d;
    logic [31:0]               hdr_seq_q, hdr_seq_d;
    logic [16:0]               bytes_q, bytes_d;
    logic [15:0]               frame_err_q, frame_err_d;
    logic [15:0]               bad_flow_q, bad_flow_d;

    logic [31:0] stat_pkt_cnt_q, stat_pkt_cnt_d;
    logic [47:0] stat_byte_cnt_q, stat_byte_cnt_d;
    logic [15:0] stat_seq_err_q, stat_seq_err_d;
    logic [15:0] stat_size_err_q, stat_size_err_d;
    logic        stat_valid_q, stat_valid_d;

    // ------------------------------------------------------ beat decoding
    logic        beat_acc;
    logic [15:0] hdr_size;
    logic [15:0] hdr_flow;
    logic [31:0] hdr_seq;
    logic        hdr_flow_ok;
    logic [16:0] last_bytes;
    logic [17:0] sum_tail;
    logic [17:0] sum_full;

    // Finalize request towards the per-flow counters
    logic                      fin_en;
    logic [FLOW_CNT_WIDTH-1:0] fin_flow;
    logic [31:0]               fin_seq;
    logic [15:0]               fin_size;
    logic [16:0]               fin_bytes;

    logic frame_inc;
    logic bad_inc;

    always_comb begin
        beat_acc    = pkt_valid_i && ready_q;
        hdr_size    = pkt_data_i[63:48];
        hdr_flow    = pkt_data_i[47:32];
        hdr_seq     = pkt_data_i[31:0];
        hdr_flow_ok = ({1'b0, hdr_flow} < FLOW_LIMIT);
        last_bytes  = {13'd0, 4'd8 - {1'b0, pkt_empty_i}};
        // One spare bit so a carry out of 17 bits can be detected and saturated
        sum_tail    = {1'b0, bytes_q} + {1'b0, last_bytes};
        sum_full    = {1'b0, bytes_q} + 18'd8;
    end

    // ------------------------------------------------------------- FSM
    always_comb begin
        state_d    = state_q;
        hdr_size_d = hdr_size_q;
        hdr_flow_d = hdr_flow_q;
        hdr_seq_d  = hdr_seq_q;
        bytes_d    = bytes_q;
        frame_inc  = 1'b0;
        bad_inc    = 1'b0;
        fin_en     = 1'b0;
        fin_flow   = hdr_flow_q;
        fin_seq    = hdr_seq_q;
        fin_size   = hdr_size_q;
        fin_bytes  = bytes_q;

        if (beat_acc) begin
            if (pkt_sop_i) begin
                // A sop inside a packet abandons it silently and restarts
                frame_inc = (state_q != ST_WAIT_SOP);
                if (!hdr_flow_ok) begin
                    bad_inc = 1'b1;
                    state_d = pkt_eop_i ? ST_WAIT_SOP : ST_DROP;
                end else begin
                    hdr_size_d = hdr_size;
                    hdr_flow_d = hdr_flow[FLOW_CNT_WIDTH-1:0];
                    hdr_seq_d  = hdr_seq;
                    if (pkt_eop_i) begin
                        // Single-beat packet: finalize straight from the beat
                        fin_en    = 1'b1;
                        fin_flow  = hdr_flow[FLOW_CNT_WIDTH-1:0];
                        fin_seq   = hdr_seq;
                        fin_size  = hdr_size;
                        fin_bytes = last_bytes;
                        bytes_d   = last_bytes;
                        state_d   = ST_WAIT_SOP;
                    end else begin
                        bytes_d = 17'd8;
                        state_d = ST_IN_PKT;
                    end
                end
            end else begin
                case (state_q)
                    ST_IN_PKT: begin
                        if (pkt_eop_i) begin
                            fin_en    = 1'b1;
                            fin_bytes = sum_tail[17] ? BYTES_SAT : sum_tail[16:0];
                            bytes_d   = fin_bytes;
                            state_d   = ST_WAIT_SOP;
                        end else begin
                            bytes_d = sum_full[17] ? BYTES_SAT : sum_full[16:0];
                        end
                    end
                    ST_DROP: begin
                        if (pkt_eop_i) begin
                            state_d = ST_WAIT_SOP;
                        end
                    end
                    default: begin
                        // Stray beat outside any packet
                        frame_inc = 1'b1;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------- global counters
    always_comb begin
        ready_d     = 1'b1;
        frame_err_d = frame_err_q;
        bad_flow_d  = bad_flow_q;
        if (frame_inc && (frame_err_q != 16'hFFFF)) begin
            frame_err_d = frame_err_q + 16'd1;
        end
        if (bad_inc && (bad_flow_q != 16'hFFFF)) begin
            bad_flow_d = bad_flow_q + 16'd1;
        end
    end

    // ------------------------------------------------ per-flow counters
    logic [31:0] pkt_cnt_arr  [FLOW_CNT];
    logic [47:0] byte_cnt_arr [FLOW_CNT];
    logic [15:0] seq_err_arr  [FLOW_CNT];
    logic [15:0] size_err_arr [FLOW_CNT];

    for (genvar gi = 0; gi < FLOW_CNT; gi++) begin : g_flow
        logic [31:0] pkt_cnt_q, pkt_cnt_d;
        logic [47:0] byte_cnt_q, byte_cnt_d;
        logic [15:0] seq_err_q, seq_err_d;
        logic [15:0] size_err_q, size_err_d;
        logic [31:0] exp_seq_q, exp_seq_d;
        logic        first_seen_q, first_seen_d;
        logic        hit_clr;
        logic        hit_fin;

        always_comb begin
            hit_clr      = stat_clr_i && (stat_addr_i == FLOW_CNT_WIDTH'(gi));
            hit_fin      = fin_en && (fin_flow == FLOW_CNT_WIDTH'(gi));
            pkt_cnt_d    = pkt_cnt_q;
            byte_cnt_d   = byte_cnt_q;
            seq_err_d    = seq_err_q;
            size_err_d   = size_err_q;
            exp_seq_d    = exp_seq_q;
            first_seen_d = first_seen_q;

            // Clear has priority: a finalize hitting a flow being cleared is lost
            if (hit_clr) begin
                pkt_cnt_d    = '0;
                byte_cnt_d   = '0;
                seq_err_d    = '0;
                size_err_d   = '0;
                first_seen_d = 1'b0;
            end else if (hit_fin) begin
                pkt_cnt_d  = pkt_cnt_q + 32'd1;
                byte_cnt_d = byte_cnt_q + {31'd0, fin_bytes};
                if ((fin_bytes != {1'b0, fin_size}) && (size_err_q != 16'hFFFF)) begin
                    size_err_d = size_err_q + 16'd1;
                end
                if (first_seen_q && (fin_seq != exp_seq_q) && (seq_err_q != 16'hFFFF)) begin
                    seq_err_d = seq_err_q + 16'd1;
                end
                // Resync to whatever arrived so one gap costs one error
                exp_seq_d    = fin_seq + 32'd1;
                first_seen_d = 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                pkt_cnt_q    <= '0;
                byte_cnt_q   <= '0;
                seq_err_q    <= '0;
                size_err_q   <= '0;
                exp_seq_q    <= '0;
                first_seen_q <= 1'b0;
            end else begin
                pkt_cnt_q    <= pkt_cnt_d;
                byte_cnt_q   <= byte_cnt_d;
                seq_err_q    <= seq_err_d;
                size_err_q   <= size_err_d;
                exp_seq_q    <= exp_seq_d;
                first_seen_q <= first_seen_d;
            end
        end

        assign pkt_cnt_arr[gi]  = pkt_cnt_q;
        assign byte_cnt_arr[gi] = byte_cnt_q;
        assign seq_err_arr[gi]  = seq_err_q;
        assign size_err_arr[gi] = size_err_q;
    end

    // ------------------------------------------------------- read port
    // Snapshot of the current (pre-update, pre-clear) register contents
    always_comb begin
        stat_valid_d    = stat_rd_en_i;
        stat_pkt_cnt_d  = stat_pkt_cnt_q;
        stat_byte_cnt_d = stat_byte_cnt_q;
        stat_seq_err_d  = stat_seq_err_q;
        stat_size_err_d = stat_size_err_q;
        if (stat_rd_en_i) begin
            stat_pkt_cnt_d  = pkt_cnt_arr[stat_addr_i];
            stat_byte_cnt_d = byte_cnt_arr[stat_addr_i];
            stat_seq_err_d  = seq_err_arr[stat_addr_i];
            stat_size_err_d = size_err_arr[stat_addr_i];
        end
    end

    // ------------------------------------------------------- registers
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q         <= ST_WAIT_SOP;
            ready_q         <= 1'b0;
            hdr_size_q      <= '0;
            hdr_flow_q      <= '0;
            hdr_seq_q       <= '0;
            bytes_q         <= '0;
            frame_err_q     <= '0;
            bad_flow_q      <= '0;
            stat_pkt_cnt_q  <= '0;
            stat_byte_cnt_q <= '0;
            stat_seq_err_q  <= '0;
            stat_size_err_q <= '0;
            stat_valid_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            ready_q         <= ready_d;
            hdr_size_q      <= hdr_size_d;
            hdr_flow_q      <= hdr_flow_d;
            hdr_seq_q       <= hdr_seq_d;
            bytes_q         <= bytes_d;
            frame_err_q     <= frame_err_d;
            bad_flow_q      <= bad_flow_d;
            stat_pkt_cnt_q  <= stat_pkt_cnt_d;
            stat_byte_cnt_q <= stat_byte_cnt_d;
            stat_seq_err_q  <= stat_seq_err_d;
            stat_size_err_q <= stat_size_err_d;
            stat_valid_q    <= stat_valid_d;
        end
    end

    assign pkt_ready_o     = ready_q;
    assign stat_pkt_cnt_o  = stat_pkt_cnt_q;
    assign stat_byte_cnt_o = stat_byte_cnt_q;
    assign stat_seq_err_o  = stat_seq_err_q;
    assign stat_size_err_o = stat_size_err_q;
    assign stat_valid_o    = stat_valid_q;
    assign frame_err_cnt_o = frame_err_q;
    assign bad_flow_cnt_o  = bad_flow_q;

endmodule

// File: doc/pkt_chk.md
# pkt_chk

Receive-side packet checker that consumes the packet stream produced by `pkt_gen` (the `pkt_if` beat stream) and tracks per-flow statistics. It parses the header word of each packet, checks the per-flow sequence number and the declared packet size, and keeps per-flow packet, byte and error counters. A register-style read/clear port exposes the counters. It sits at the far end of a loopback or DUT path and closes the `pkt_gen_top` traffic loop.

## Interface
- `FLOW_CNT`, 16: number of flows tracked.
- `FLOW_CNT_WIDTH`, `(FLOW_CNT==1) ? 1 : $clog2(FLOW_CNT)`: internal parameter, not overridden.

Ports:
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset, synchronous, active-low.
- `pkt_data_i` in 64: beat data. Byte 0 is `[63:56]`.
- `pkt_sop_i` in 1: first beat of a packet.
- `pkt_eop_i` in 1: last beat of a packet.
- `pkt_empty_i` in 3: count of unused bytes on the eop beat. Ignored on other beats.
- `pkt_valid_i` in 1: beat valid.
- `pkt_ready_o` out 1: beat accepted when `valid && ready`.
- `stat_addr_i` in FLOW_CNT_WIDTH: flow to read or clear.
- `stat_rd_en_i` in 1: read request.
- `stat_clr_i` in 1: clear all counters of `stat_addr_i`.
- `stat_pkt_cnt_o` out 32: packet count of the flow.
- `stat_byte_cnt_o` out 48: byte count of the flow.
- `stat_seq_err_o` out 16: sequence-error count of the flow.
- `stat_size_err_o` out 16: size-error count of the flow.
- `stat_valid_o` out 1: read data valid.
- `frame_err_cnt_o` out 16: global count of framing errors.
- `bad_flow_cnt_o` out 16: global count of packets whose flow number is out of range.

## Operation
Header format, on the sop beat:
- `[63:48]` = declared pkt_size in bytes.
- `[47:32]` = flow number; only the low FLOW_CNT_WIDTH bits are used, and the upper bits must be zero.
- `[31:0]` = sequence number.

FSM states are WAIT_SOP, IN_PKT and DROP. Reset state is WAIT_SOP.
- **WAIT_SOP, accepted sop beat**: latch the header and set `bytes = 8`. If `eop` is also set, this is a single-beat packet: set `bytes = 8 - empty` and finalize. Otherwise go to IN_PKT.
  - If the flow number is ≥ FLOW_CNT: increment `bad_flow_cnt` and go to DROP, or stay in WAIT_SOP if `eop` is set.
- **WAIT_SOP, accepted beat without sop**: increment `frame_err_cnt` and discard the beat.
- **IN_PKT, accepted beat**: `bytes += 8`. On `eop`, `bytes += 8 - empty` instead, finalize, and go to WAIT_SOP.
- **IN_PKT, accepted sop beat**: increment `frame_err_cnt`, abandon the current packet without a stats update, and treat the beat as a new sop.
- **DROP**: discard beats until `eop`, then go to WAIT_SOP. A sop in DROP follows the same rule as a sop in IN_PKT.
- **Finalize** updates flow f:
  - `pkt_cnt += 1`.
  - `byte_cnt += bytes`.
  - If `bytes != pkt_size`, increment `size_err`.
  - If `seq != exp_seq[f]` and `first_seen[f]` is set, increment `seq_err`.
  - Always set `exp_seq[f] = seq + 1` (resync to the received value) and set `first_seen[f]`.
- **Width rules**:
  - `bytes` is 17 bits; on overflow it saturates at `0x1FFFF`, which guarantees a size error.
  - `pkt_cnt`, `byte_cnt` and `exp_seq` wrap modulo 2^N.
  - All 16-bit error counters, including the global ones, saturate at `0xFFFF`.
- **`pkt_ready_o`**: 0 in reset, 1 at all other times. The block never back-pressures.
- **Clear**: `stat_clr_i` zeroes `pkt_cnt`, `byte_cnt`, `seq_err`, `size_err` and `first_seen` of the addressed flow. If a finalize targets the same flow in the same cycle, the clear wins and the update is lost.
- **Read**: the snapshot is taken from the pre-update register values of the request cycle.

## Timing
- Reset (`rst_i = 0` at a rising edge):
  - all counters, `exp_seq` and `first_seen` go to 0;
  - all outputs go to 0, including `pkt_ready_o` and `stat_valid_o`;
  - the FSM returns to WAIT_SOP.
- Reset mid-packet discards the partial packet.
- Per-flow stats are visible one cycle after the eop beat is accepted, i.e. a registered update.
- Read latency is 1 cycle: `stat_valid_o` pulses high for one cycle, and data is held until the next read.
- `stat_rd_en_i` and `stat_clr_i` in the same cycle: the read returns the pre-clear values.
- Global counters update the cycle after the causing beat.
- Throughput is one beat per cycle, with back-to-back packets (eop followed immediately by sop) at no penalty.

## Test plan
- **Basic traffic**: flow 3, sizes 64 and 65 bytes (8 beats `empty=0`; 9 beats `eop empty=7`), seq 0 and 1. Required: read flow 3 gives pkt=2, byte=129, seq_err=0, size_err=0.
- **Sequence gap**: flow 5 sends seq 10, 11, 13, 14. Required: seq_err=1, pkt=4; the first packet (seq 10) does not count as an error.
- **Size mismatch and single beat**: header size=100 with 96 bytes sent gives size_err=1. A single-beat packet (sop+eop, `empty=2`) with size=6 gives byte += 6 and no error.
- **Framing**: a beat without sop in WAIT_SOP, then a sop mid-packet. Required: frame_err=2, and only the second packet is counted.
- **Out-of-range flow**: flow number 20 with FLOW_CNT=16 gives bad_flow=1 and no per-flow counter changes. A clear of flow 3 in the same cycle as its eop leaves pkt=0.
- **Reset mid-packet**: assert `rst_i=0` during beat 4 of an 8-beat packet. Required: all counters 0, `ready=0` during reset, and the next full packet counts as pkt=1.
